// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared state encodings, trap causes and RV32I opcodes for the core sequencer
package core_ctrl_pkg;

    localparam int CTRL_STATE_WIDTH = 3;

    typedef enum logic [CTRL_STATE_WIDTH-1:0] {
        ST_IDLE   = 3'b000,
        ST_FETCH  = 3'b001,
        ST_DECODE = 3'b010,
        ST_EXEC   = 3'b011,
        ST_MEM    = 3'b100,
        ST_WB     = 3'b101,
        ST_TRAP   = 3'b110
    } ctrl_state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_IMEM    = 2'b01;
    localparam logic [1:0] CAUSE_DMEM    = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b11;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ECALL/EBREAK share SYSTEM with func3 == 000 and are treated as illegal here
    function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
        logic legal;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_FENCE: legal = 1'b1;
            OP_SYSTEM: legal = (f3 != 3'b000);
            default:   legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/core_ctrl_bus_wait_timer.sv
// rtl/core_ctrl_bus_wait_timer.sv - saturating wait counter flagging a bus request that outlived its timeout
module bus_wait_timer #(
    parameter int BUS_TIMEOUT = 255,
    parameter int TIMER_WIDTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam logic [TIMER_WIDTH-1:0] LIMIT = TIMER_WIDTH'(BUS_TIMEOUT);

    logic [TIMER_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + TIMER_WIDTH'(1);
        end
    end

    assign timeout = (count == LIMIT);

endmodule

// File: rtl/core_ctrl.sv
// rtl/core_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with bus timeout and illegal-opcode traps
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255,
    parameter int TIMER_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic        wb_reg_dec,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic        csr_we,
    output logic [31:0] instret,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    logic [1:0]  cause_d;
    logic        waiting;
    logic        ack_sel;
    logic        timeout;

    assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign ack_sel = (state_q == ST_FETCH) ? imem_ack : dmem_ack;

    // One timer serves both waits; it is held clear whenever no request is outstanding
    bus_wait_timer #(
        .BUS_TIMEOUT (BUS_TIMEOUT),
        .TIMER_WIDTH (TIMER_WIDTH)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!waiting),
        .enable  (waiting && !ack_sel),
        .timeout (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = CAUSE_NONE;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_IMEM;
                end
            end
            ST_DECODE: begin
                if (is_legal(opcode, func3)) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC:   state_d = ((opcode == OP_LOAD) || (opcode == OP_STORE)) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (dmem_ack) begin
                    state_d = ST_WB;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_DMEM;
                end
            end
            ST_WB:     state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        reg_we   = 1'b0;
        csr_we   = 1'b0;
        trap     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_STORE);
            end
            ST_WB: begin
                pc_we = 1'b1;
                if (opcode == OP_SYSTEM) begin
                    reg_we = 1'b1;
                    csr_we = 1'b1;
                end else begin
                    reg_we = wb_reg_dec && (opcode != OP_BRANCH) &&
                             (opcode != OP_STORE) && (opcode != OP_FENCE);
                end
            end
            ST_TRAP:  trap = 1'b1;
            default:  ;
        endcase
    end

    // Cause is captured only on the transition into TRAP so it stays stable while halted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_cause <= CAUSE_NONE;
            instret    <= '0;
        end else begin
            if ((state_q != ST_TRAP) && (state_d == ST_TRAP)) begin
                trap_cause <= cause_d;
            end
            if (state_q == ST_WB) begin
                instret <= instret + 32'd1;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_core_ctrl.sv
// tb/tb_core_ctrl.sv - table-driven checks of core_ctrl sequencing, gating, timeouts, traps and reset
module tb_core_ctrl;
    import core_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  func3 = 3'd0;
    logic        wb_reg_dec = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, csr_we, trap;
    logic [31:0] instret;
    logic [1:0]  trap_cause;
    logic [2:0]  state;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_instret = 32'd0;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       wb;
        int         iw;
        int         dw;
        logic       stray;
        int         cyc;
        int         irn;
        int         pcn;
        int         regn;
        int         csrn;
        int         memn;
        int         dwen;
        logic       trp;
        logic [1:0] cause;
    } vec_t;

    vec_t vecs[18];

    core_ctrl #(.BUS_TIMEOUT(4), .TIMER_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .func3      (func3),
        .wb_reg_dec (wb_reg_dec),
        .imem_ack   (imem_ack),
        .dmem_ack   (dmem_ack),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .reg_we     (reg_we),
        .csr_we     (csr_we),
        .instret    (instret),
        .trap       (trap),
        .trap_cause (trap_cause),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_outputs", {imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, csr_we, trap}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_cause", 32'(trap_cause), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("idle_after_release", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        chk("fetch_cycle2", 32'(state), 32'd1);
        chk("imem_req_cycle2", 32'(imem_req), 32'd1);
        exp_instret = 32'd0;
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc = 0, fcnt = 0, mcnt = 0;
        int   irn = 0, pcn = 0, regn = 0, csrn = 0, memn = 0, dwen = 0, hold = 0;
        logic left = 1'b0;
        opcode = v.op;
        func3 = v.f3;
        wb_reg_dec = v.wb;
        do begin
            @(negedge clk);
            imem_ack = (state == 3'd1) ? (fcnt == v.iw) : v.stray;
            dmem_ack = (state == 3'd4) ? (mcnt == v.dw) : v.stray;
            #1;
            irn  += int'(ir_we);
            pcn  += int'(pc_we);
            regn += int'(reg_we);
            csrn += int'(csr_we);
            memn += int'(dmem_req);
            dwen += int'(dmem_we);
            if (state == 3'd1) fcnt++;
            if (state == 3'd4) mcnt++;
            cyc++;
            @(posedge clk);
            #1;
            if (state != 3'd1) left = 1'b1;
        end while (!((state == 3'd6) || (left && state == 3'd1)) && cyc < 40);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        chk({v.name, "_cycles"}, cyc, v.cyc);
        chk({v.name, "_ir_we"}, irn, v.irn);
        chk({v.name, "_pc_we"}, pcn, v.pcn);
        chk({v.name, "_reg_we"}, regn, v.regn);
        chk({v.name, "_csr_we"}, csrn, v.csrn);
        chk({v.name, "_dmem_req"}, memn, v.memn);
        chk({v.name, "_dmem_we"}, dwen, v.dwen);
        chk({v.name, "_trap"}, 32'(trap), 32'(v.trp));
        if (!v.trp) exp_instret = exp_instret + 32'd1;
        chk({v.name, "_instret"}, instret, exp_instret);
        if (v.trp) begin
            chk({v.name, "_cause"}, 32'(trap_cause), 32'(v.cause));
            chk({v.name, "_reqs_low"}, {imem_req, dmem_req}, 32'd0);
            imem_ack = 1'b1;
            dmem_ack = 1'b1;
            repeat (3) begin
                @(negedge clk);
                hold += int'(imem_req) + int'(dmem_req) + int'(ir_we) + int'(pc_we) + int'(reg_we) + int'(csr_we);
            end
            chk({v.name, "_trap_absorb"}, 32'(state), 32'd6);
            chk({v.name, "_trap_quiet"}, hold, 0);
            chk({v.name, "_cause_held"}, 32'(trap_cause), 32'(v.cause));
            chk({v.name, "_instret_frozen"}, instret, exp_instret);
            do_reset();
        end
    endtask

    task automatic mid_mem_reset();
        int n = 0;
        opcode = OP_LOAD;
        func3 = 3'b010;
        wb_reg_dec = 1'b1;
        while (state != 3'd4 && n < 10) begin
            @(negedge clk);
            imem_ack = (state == 3'd1);
            dmem_ack = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        imem_ack = 1'b0;
        chk("midmem_dmem_req", 32'(dmem_req), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midmem_async_drop", {dmem_req, dmem_we}, 32'd0);
        chk("midmem_async_state", 32'(state), 32'd0);
        chk("midmem_instret_clr", instret, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midmem_idle", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        chk("midmem_fetch", 32'(state), 32'd1);
        exp_instret = 32'd0;
    endtask

    initial begin
        //           name       op         f3      wb    iw  dw  stray cyc ir pc reg csr mem dwe trap cause
        vecs[0]  = '{"addi",    OP_IMM,    3'b000, 1'b1, 0,  0,  1'b0, 4, 1, 1, 1, 0, 0, 0, 1'b0, 2'b00};
        vecs[1]  = '{"lw_d3",   OP_LOAD,   3'b010, 1'b1, 0,  3,  1'b0, 8, 1, 1, 1, 0, 4, 0, 1'b0, 2'b00};
        vecs[2]  = '{"sw",      OP_STORE,  3'b010, 1'b1, 0,  0,  1'b0, 5, 1, 1, 0, 0, 1, 1, 1'b0, 2'b00};
        vecs[3]  = '{"beq",     OP_BRANCH, 3'b000, 1'b1, 0,  0,  1'b0, 4, 1, 1, 0, 0, 0, 0, 1'b0, 2'b00};
        vecs[4]  = '{"lui_i2",  OP_LUI,    3'b000, 1'b1, 2,  0,  1'b0, 6, 1, 1, 1, 0, 0, 0, 1'b0, 2'b00};
        vecs[5]  = '{"jal_str", OP_JAL,    3'b000, 1'b1, 0,  0,  1'b1, 4, 1, 1, 1, 0, 0, 0, 1'b0, 2'b00};
        vecs[6]  = '{"csrrw",   OP_SYSTEM, 3'b001, 1'b0, 0,  0,  1'b0, 4, 1, 1, 1, 1, 0, 0, 1'b0, 2'b00};
        vecs[7]  = '{"fence",   OP_FENCE,  3'b000, 1'b1, 0,  0,  1'b0, 4, 1, 1, 0, 0, 0, 0, 1'b0, 2'b00};
        vecs[8]  = '{"add_nwb", OP_REG,    3'b000, 1'b0, 0,  0,  1'b0, 4, 1, 1, 0, 0, 0, 0, 1'b0, 2'b00};
        vecs[9]  = '{"jalr",    OP_JALR,   3'b000, 1'b1, 0,  0,  1'b0, 4, 1, 1, 1, 0, 0, 0, 1'b0, 2'b00};
        vecs[10] = '{"i_edge",  OP_AUIPC,  3'b000, 1'b1, 4,  0,  1'b0, 8, 1, 1, 1, 0, 0, 0, 1'b0, 2'b00};
        vecs[11] = '{"d_edge",  OP_LOAD,   3'b000, 1'b1, 0,  4,  1'b0, 9, 1, 1, 1, 0, 5, 0, 1'b0, 2'b00};
        vecs[12] = '{"sw_str",  OP_STORE,  3'b000, 1'b0, 0,  1,  1'b1, 6, 1, 1, 0, 0, 2, 2, 1'b0, 2'b00};
        vecs[13] = '{"ill_7f",  7'h7f,     3'b000, 1'b1, 0,  0,  1'b0, 2, 1, 0, 0, 0, 0, 0, 1'b1, 2'b11};
        vecs[14] = '{"ecall",   OP_SYSTEM, 3'b000, 1'b1, 0,  0,  1'b0, 2, 1, 0, 0, 0, 0, 0, 1'b1, 2'b11};
        vecs[15] = '{"i_tmo",   OP_IMM,    3'b000, 1'b1, 99, 0,  1'b0, 5, 0, 0, 0, 0, 0, 0, 1'b1, 2'b01};
        vecs[16] = '{"d_tmo",   OP_LOAD,   3'b010, 1'b1, 0,  99, 1'b0, 8, 1, 0, 0, 0, 5, 0, 1'b1, 2'b10};
        vecs[17] = '{"sw_tmo",  OP_STORE,  3'b010, 1'b0, 0,  99, 1'b0, 8, 1, 0, 0, 0, 5, 5, 1'b1, 2'b10};

        do_reset();
        for (int i = 0; i < 18; i++) begin
            if (i == 13) mid_mem_reset();
            run_vec(vecs[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_ctrl.md
Name: core_ctrl

Overview:
- Multi-cycle sequencer for the core. Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the instruction and data memory request handshakes, the instruction-register and PC update strobes, and the final register/CSR write enables.
- Gates the decoder's wb_reg/wb_csr so architectural state changes exactly once per instruction.
- Detects illegal opcodes and bus timeouts, and counts retired instructions for the CSR file.

Parameters:
- BUS_TIMEOUT, 255, max cycles a request may wait for its ack before trapping (1..65535).
- TIMER_WIDTH, 16, width of the wait counter; must satisfy 2**TIMER_WIDTH > BUS_TIMEOUT.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  7  code[6:0] of the latched instruction.
- func3  input  3  code[14:12] of the latched instruction.
- wb_reg_dec  input  1  register write-back request from decode.
- imem_ack  input  1  instruction memory response valid; code is valid in the same cycle.
- dmem_ack  input  1  data memory response/complete.
- imem_req  output  1  instruction fetch request.
- dmem_req  output  1  data access request.
- dmem_we  output  1  data access is a store.
- ir_we  output  1  latch instruction word into the IR.
- pc_we  output  1  commit the next PC (the pc_sel-selected value).
- reg_we  output  1  register file write enable.
- csr_we  output  1  CSR write enable.
- instret  output  32  retired-instruction count.
- trap  output  1  core halted.
- trap_cause  output  2  01 = imem timeout, 10 = dmem timeout, 11 = illegal instruction.
- state  output  3  current FSM state, for debug.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; all strobes and requests 0; instret = 0; trap = 0; trap_cause = 00; wait counter = 0.
  - Reset asserted mid-operation aborts immediately; a request drops in the same cycle reset asserts.
- State encoding: IDLE 000, FETCH 001, DECODE 010, EXEC 011, MEM 100, WB 101, TRAP 110.
- IDLE: one cycle after reset release, then go to FETCH.
- FETCH:
  - imem_req = 1 until imem_ack is sampled high.
  - In the ack cycle, ir_we = 1 (one-cycle pulse) and the next state is DECODE.
- DECODE (one cycle): classify opcode.
  - Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, and 1110011 with func3 != 000.
  - Anything else, including ECALL/EBREAK (1110011, func3 = 000), goes to TRAP with cause 11.
  - Legal opcodes go to EXEC.
- EXEC: one cycle for ALU settle. LOAD (0000011) and STORE (0100011) go to MEM; all others go to WB.
- MEM:
  - dmem_req = 1, dmem_we = (opcode == 0100011), held until dmem_ack.
  - dmem_ack then goes to WB.
- WB (one cycle):
  - pc_we = 1.
  - reg_we = wb_reg_dec AND opcode not in {1100011, 0100011, 0001111}; reg_we = 1 for legal SYSTEM.
  - csr_we = 1 only for legal SYSTEM.
  - instret increments by 1, wrapping 0xFFFFFFFF to 0.
  - Next state FETCH.
- TRAP:
  - Absorbing state until reset. trap = 1 and trap_cause is held.
  - All requests and strobes 0; instret frozen.
- Strobe rule: ir_we, pc_we, reg_we and csr_we are each high for at most one cycle per instruction and never outside their own state.
- Wait timer:
  - Clears on entry to FETCH/MEM and counts each cycle the request is high without ack.
  - When the count reaches BUS_TIMEOUT with no ack, go to TRAP with cause 01 (FETCH) or 10 (MEM).
  - Ack in the same cycle as the timeout: ack wins, no trap.
- Acks sampled outside FETCH/MEM are ignored.
- Latency with zero-wait memory:
  - ALU/branch/jump/CSR: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
  - Each wait cycle adds 1.
- Outputs are Moore-decoded from state. Exception: ir_we is qualified by imem_ack.

Decomposition:
- param_ctrl_state.vh: state encodings, CTRL_STATE_WIDTH, trap cause codes.
- param_opcode.vh: the RV32I opcode constants, shared with decode.
- One sub-module, bus_wait_timer: clear/enable/count, timeout flag, parameterised by BUS_TIMEOUT and TIMER_WIDTH. It is reused for both the FETCH and MEM waits.

Test Plan:
- Reset then ADDI (0x00100093) with immediate imem_ack:
  - imem_req high in cycle 2, ir_we in cycle 2, reg_we and pc_we in cycle 5.
  - instret = 1 afterwards.
- LW with dmem_ack delayed 3 cycles:
  - dmem_req and dmem_we = 0 held 4 cycles, reg_we one cycle later.
  - Total 8 cycles; instret increments once.
- SW then BEQ:
  - SW: dmem_we = 1, reg_we = 0 in WB.
  - BEQ: no MEM state, reg_we = 0, pc_we = 1.
  - instret = 2.
- imem_ack never asserted with BUS_TIMEOUT = 4:
  - Enter TRAP after 4 wait cycles, trap_cause = 01, imem_req drops.
  - Ack arriving in the fifth cycle (timeout cycle) instead proceeds to DECODE.
- Opcode 0x0000007F, then ECALL (0x00000073):
  - Each goes to TRAP cause 11 from DECODE, with no reg_we/csr_we/pc_we pulse.
- rst_n low during MEM with dmem_req high:
  - dmem_req is 0 immediately (asynchronously).
  - After release: IDLE, then FETCH; instret = 0.
